// File: rtl/masked_rand_supply_pkg.sv
// Shared constants, state encoding and the single LFSR step for the masked randomness supply.
// Polynomial x^64+x^63+x^61+x^60+1 (Fibonacci form, maximal length).
package masked_rand_supply_pkg;

    localparam int LFSR_W = 64;

    localparam int TAP_A = 63;
    localparam int TAP_B = 62;
    localparam int TAP_C = 60;
    localparam int TAP_D = 59;

    // An all-zero LFSR would lock up, so a zero seed is replaced by this word.
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WARM = 2'd2,
        RUN  = 2'd3
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
        return {s[LFSR_W-2:0], fb};
    endfunction

endpackage

// File: rtl/lfsr64_unrolled.sv
// One 64-bit Fibonacci LFSR that applies STEPS_PER_ADV single steps per advance.
// Load has priority over advance; a zero seed is substituted so the register never locks up.
module lfsr64_unrolled
    import masked_rand_supply_pkg::*;
#(
    parameter int STEPS_PER_ADV = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] stepped;

    always_comb begin
        stepped = state;
        for (int i = 0; i < STEPS_PER_ADV; i++) begin
            stepped = lfsr_step(stepped);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? ZERO_SEED_SUB : seed;
        end else if (adv) begin
            state <= stepped;
        end
    end

endmodule

// File: rtl/masked_rand_supply.sv
// Fresh-mask supply for the masked S-box pair: seeded LFSR bank, warm-up, gated output.
// Optional macro RAND_HEALTH_EN adds a sticky health_err flag for an all-zero LFSR.
module masked_rand_supply
    import masked_rand_supply_pkg::*;
#(
    parameter int NUM_LFSR      = 3,
    parameter int STEPS_PER_ADV = 64,
    parameter int WARMUP_CYCLES = 128,
    localparam int R_WIDTH      = LFSR_W * NUM_LFSR,
    localparam int BEAT_W       = (NUM_LFSR > 1) ? $clog2(NUM_LFSR) : 1
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               seed_valid,
    output logic               seed_ready,
    input  logic [LFSR_W-1:0]  seed_data,
    input  logic               r_en,
    output logic [R_WIDTH-1:0] r,
    output logic               r_valid,
`ifdef RAND_HEALTH_EN
    output logic               health_err,
`endif
    output state_e             dbg_state,
    output logic [BEAT_W-1:0]  dbg_beat
);

    // Seed handshake: a beat transfers on a rising clock edge where seed_valid && seed_ready.
    localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam state_e AFTER_LOAD = (WARMUP_CYCLES == 0) ? RUN : WARM;

    state_e              state, state_nx;
    logic [BEAT_W-1:0]   beat, beat_nx;
    logic [WARM_W-1:0]   warm_cnt, warm_cnt_nx;
    logic                armed;
    logic                hs;
    logic                adv;
    logic                load_en;
    logic [BEAT_W-1:0]   load_idx;
    logic [NUM_LFSR-1:0] load;
    logic [LFSR_W-1:0]   lfsr_q [NUM_LFSR];
    logic [R_WIDTH-1:0]  lfsr_cat;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            beat     <= '0;
            warm_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_nx;
            beat     <= beat_nx;
            warm_cnt <= warm_cnt_nx;
            armed    <= 1'b1;
        end
    end

    // armed keeps seed_ready low until the first edge after reset release.
    always_comb begin
        seed_ready  = armed && (state != WARM);
        hs          = seed_valid && seed_ready;
        state_nx    = state;
        beat_nx     = beat;
        warm_cnt_nx = warm_cnt;
        adv         = 1'b0;
        load_en     = 1'b0;
        load_idx    = '0;
        case (state)
            IDLE, RUN: begin
                if (hs) begin
                    load_en = 1'b1;
                    if (NUM_LFSR == 1) begin
                        state_nx = AFTER_LOAD;
                    end else begin
                        state_nx = LOAD;
                        beat_nx  = BEAT_W'(1);
                    end
                end else if (state == RUN && r_en) begin
                    adv = 1'b1;
                end
            end
            LOAD: begin
                if (hs) begin
                    load_en  = 1'b1;
                    load_idx = beat;
                    if (beat == BEAT_W'(NUM_LFSR - 1)) begin
                        beat_nx  = '0;
                        state_nx = AFTER_LOAD;
                    end else begin
                        beat_nx = beat + 1'b1;
                    end
                end
            end
            WARM: begin
                adv = 1'b1;
                if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
                    warm_cnt_nx = '0;
                    state_nx    = RUN;
                end else begin
                    warm_cnt_nx = warm_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_LFSR; i++) begin : gen_lfsr
        assign load[i] = load_en && (load_idx == BEAT_W'(i));

        lfsr64_unrolled #(
            .STEPS_PER_ADV(STEPS_PER_ADV)
        ) u_lfsr (
            .clk  (clk),
            .rst  (rst_i),
            .load (load[i]),
            .seed (seed_data),
            .adv  (adv),
            .state(lfsr_q[i])
        );

        assign lfsr_cat[i*LFSR_W +: LFSR_W] = lfsr_q[i];
    end

`ifdef RAND_HEALTH_EN
    logic any_zero;

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_LFSR; i++) begin
            if (lfsr_q[i] == '0) any_zero = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            health_err <= 1'b0;
        end else if ((state == WARM || state == RUN) && any_zero) begin
            health_err <= 1'b1;
        end
    end

    assign r_valid = (state == RUN) && !health_err;
`else
    assign r_valid = (state == RUN);
`endif

    // Only registered values feed r, so masking on r_valid cannot leak next-state glitches.
    assign r         = lfsr_cat & {R_WIDTH{r_valid}};
    assign dbg_state = state;
    assign dbg_beat  = beat;

endmodule

// File: tb/tb_masked_rand_supply.sv
// Bench for masked_rand_supply: two instances (1 and 64 steps per advance) in lockstep,
// checked against a reference LFSR model through expected-value queues.
module tb_masked_rand_supply;
    import masked_rand_supply_pkg::*;

    localparam int RW = 192;

    logic          clk = 1'b0;
    logic          rst_i = 1'b0;
    logic          seed_valid = 1'b0;
    logic [63:0]   seed_data = '0;
    logic          r_en = 1'b0;

    logic          seed_ready_a, seed_ready_b;
    logic [RW-1:0] r_a, r_b;
    logic          r_valid_a, r_valid_b;
    state_e        dbg_state_a, dbg_state_b;
    logic [1:0]    dbg_beat_a, dbg_beat_b;
`ifdef RAND_HEALTH_EN
    logic          health_err_a, health_err_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0]   ma [3];
    logic [63:0]   mb [3];
    logic [RW-1:0] exp_a_q[$];
    logic [RW-1:0] exp_b_q[$];

    always #5 clk = ~clk;

    masked_rand_supply #(.NUM_LFSR(3), .STEPS_PER_ADV(1), .WARMUP_CYCLES(4)) dut_a (
        .clk(clk), .rst_i(rst_i), .seed_valid(seed_valid), .seed_ready(seed_ready_a),
        .seed_data(seed_data), .r_en(r_en), .r(r_a), .r_valid(r_valid_a),
`ifdef RAND_HEALTH_EN
        .health_err(health_err_a),
`endif
        .dbg_state(dbg_state_a), .dbg_beat(dbg_beat_a)
    );

    masked_rand_supply #(.NUM_LFSR(3), .STEPS_PER_ADV(64), .WARMUP_CYCLES(4)) dut_b (
        .clk(clk), .rst_i(rst_i), .seed_valid(seed_valid), .seed_ready(seed_ready_b),
        .seed_data(seed_data), .r_en(r_en), .r(r_b), .r_valid(r_valid_b),
`ifdef RAND_HEALTH_EN
        .health_err(health_err_b),
`endif
        .dbg_state(dbg_state_b), .dbg_beat(dbg_beat_b)
    );

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] step_n(input logic [63:0] s, input int n);
        logic [63:0] v;
        v = s;
        for (int i = 0; i < n; i++) v = {v[62:0], v[63] ^ v[62] ^ v[60] ^ v[59]};
        return v;
    endfunction

    function automatic logic [63:0] guard(input logic [63:0] v);
        return (v == 64'h0) ? 64'h1 : v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic advance_models();
        for (int i = 0; i < 3; i++) begin
            ma[i] = step_n(ma[i], 1);
            mb[i] = step_n(mb[i], 64);
        end
    endtask

    task automatic push_exp();
        exp_a_q.push_back({ma[2], ma[1], ma[0]});
        exp_b_q.push_back({mb[2], mb[1], mb[0]});
    endtask

    task automatic compare_out(input string tag);
        if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
            check({tag, "_queue_empty"}, 1, 0);
        end else begin
            check({tag, "_r_a"}, r_a, exp_a_q.pop_front());
            check({tag, "_r_b"}, r_b, exp_b_q.pop_front());
        end
    endtask

    task automatic seed_beat(input logic [63:0] v, input int idx, input logic en_r);
        check("seed_ready_a", seed_ready_a, 1);
        check("seed_ready_b", seed_ready_b, 1);
        seed_valid = 1'b1;
        seed_data  = v;
        r_en       = en_r;
        tick();
        seed_valid = 1'b0;
        r_en       = 1'b0;
        seed_data  = {$urandom, $urandom};
        ma[idx]    = guard(v);
        mb[idx]    = guard(v);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("rst_r", r_a, '0);
        check("rst_r_valid", r_valid_a, 0);
        check("rst_seed_ready", seed_ready_a, 0);
        check("rst_state", dbg_state_a, IDLE);
        check("rst_beat", dbg_beat_a, 0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check("rel_seed_ready_low", seed_ready_a, 0);
        tick();
        check("rel_seed_ready_a", seed_ready_a, 1);
        check("rel_seed_ready_b", seed_ready_b, 1);
        for (int i = 0; i < 3; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
    endtask

    task automatic warm_and_check(input string tag);
        check({tag, "_state_warm"}, dbg_state_a, WARM);
        check({tag, "_seed_ready_warm"}, seed_ready_a, 0);
        for (int k = 1; k <= 4; k++) begin
            r_en = 1'($urandom_range(0, 1));
            tick();
            advance_models();
            check({tag, "_valid_a"}, r_valid_a, (k == 4));
            check({tag, "_valid_b"}, r_valid_b, (k == 4));
            if (k < 4) check({tag, "_gated"}, r_a, '0);
        end
        r_en = 1'b0;
        push_exp();
        compare_out(tag);
    endtask

    // mode 0: hold, 1: advance every cycle, 2: random advance pattern.
    task automatic run_cycles(input string tag, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            r_en = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            if (r_en) advance_models();
            push_exp();
            tick();
            compare_out(tag);
        end
        r_en = 1'b0;
    endtask

    initial begin
        do_reset();

        // Nominal seeding with the small known words.
        seed_beat(64'h1, 0, 0);
        seed_beat(64'h2, 1, 0);
        seed_beat(64'h3, 2, 0);
        warm_and_check("nom");
        check("nom_r0", r_a[63:0], 64'h10);
        check("nom_r1", r_a[127:64], 64'h20);
        check("nom_r2", r_a[191:128], 64'h30);

        run_cycles("hold", 5, 0);
        run_cycles("pulse", 1, 1);
        run_cycles("rand", 20, 2);
        run_cycles("burst", 4, 1);

        // Reseed in RUN with r_en in the same cycle; zero word on LFSR[0].
        seed_beat(64'h0, 0, 1);
        check("reseed_valid", r_valid_a, 0);
        check("reseed_r", r_a, '0);
        check("reseed_state", dbg_state_a, LOAD);
        check("reseed_beat", dbg_beat_a, 1);
        seed_beat({$urandom, $urandom}, 1, 0);
        seed_beat({$urandom, $urandom}, 2, 0);
        warm_and_check("reseed");
        run_cycles("reseed_run", 20, 2);
`ifdef RAND_HEALTH_EN
        check("zero_seed_health", health_err_a, 0);
`endif

        // A partial seed sequence is dropped by reset.
        seed_beat({$urandom, $urandom}, 0, 0);
        check("partial_state", dbg_state_a, LOAD);
        do_reset();
        check("partial_after_state", dbg_state_b, IDLE);
        check("partial_after_r", r_b, '0);
        seed_beat({$urandom, $urandom}, 0, 0);
        seed_beat({$urandom, $urandom}, 1, 0);
        seed_beat({$urandom, $urandom}, 2, 0);
        warm_and_check("fresh");
        run_cycles("fresh_run", 12, 2);

`ifdef RAND_HEALTH_EN
        force dut_a.gen_lfsr[0].u_lfsr.state = 64'h0;
        tick();
        release dut_a.gen_lfsr[0].u_lfsr.state;
        check("health_set", health_err_a, 1);
        check("health_valid", r_valid_a, 0);
        repeat (3) tick();
        check("health_sticky", health_err_a, 1);
        check("health_valid_sticky", r_valid_a, 0);
        do_reset();
        check("health_cleared", health_err_a, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
